// File: rtl/int_injector.sv
// int_injector: register-programmable multi-channel external interrupt generator
module int_injector #(
    parameter int          N_CH      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
    parameter logic [31:0] PC_LO     = 32'h0000_3000,
    parameter logic [31:0] PC_HI     = 32'h0000_417f,
    parameter int          PERIOD_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     macroscopic_pc,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic [3:0]      byteen,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq
);
    localparam int DEPTH = int'((PC_HI - PC_LO + 32'd1) >> 2);
    localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [29:0]         wi;
    logic [31:0]         m, w, pc_off;
    logic                we, cw, vw, pc_hit, unused_ok;
    logic [2*N_CH-1:0]   ctrl, ctrl_n;
    logic [N_CH-1:0]     pending, set_m, clr_m, fire, pw, enter;
    logic [PERIOD_W-1:0] period [N_CH];
    logic [PERIOD_W-1:0] cnt [N_CH];
    logic [PERIOD_W-1:0] pnew [N_CH];
    logic [DEPTH-1:0]    visited;

    assign wi        = addr[31:2] - BASE_ADDR[31:2];
    assign we        = |byteen;
    assign cw        = we && wi == 30'd1;
    assign vw        = we && wi == 30'd4;
    assign m         = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    assign w         = {macroscopic_pc[31:2], 2'b00};
    assign pc_off    = w - PC_LO;
    assign pc_hit    = ctrl[1:0] == 2'b01 && !pending[0] && w >= PC_LO && w <= PC_HI && !visited[pc_off[IW+1:2]];
    assign irq       = pending;
    assign unused_ok = ^{addr[1:0], macroscopic_pc[1:0], wdata, pc_off};

    // decode writes, per-channel period events and combinational read data
    always_comb begin
        ctrl_n = (ctrl & ~m[2*N_CH-1:0]) | (wdata[2*N_CH-1:0] & m[2*N_CH-1:0]);
        set_m  = (we && wi == 30'd2) ? (wdata[N_CH-1:0] & m[N_CH-1:0]) : '0;
        clr_m  = (we && wi == 30'd0) ? '1 : (we && wi == 30'd3) ? (wdata[N_CH-1:0] & m[N_CH-1:0]) : '0;
        rdata  = wi == 30'd0 ? 32'(pending) : wi == 30'd1 ? 32'(ctrl) : '0;
        for (int i = 0; i < N_CH; i++) begin
            pw[i]    = we && wi == 30'(8 + i);
            pnew[i]  = (period[i] & ~m[PERIOD_W-1:0]) | (wdata[PERIOD_W-1:0] & m[PERIOD_W-1:0]);
            enter[i] = cw && ctrl_n[2*i+:2] == 2'b10 && ctrl[2*i+:2] != 2'b10;
            fire[i]  = ctrl[2*i+:2] == 2'b10 && cnt[i] == PERIOD_W'(1) && !pw[i];
            if (wi == 30'(8 + i))
                rdata = 32'(period[i]);
        end
        set_m    = set_m | fire;
        set_m[0] = set_m[0] | pc_hit;
    end

    // register file, pending bits, visited bitmap and period counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl    <= (2*N_CH)'(1);
            pending <= '0;
            visited <= '0;
            for (int i = 0; i < N_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            if (cw)
                ctrl <= ctrl_n;
            pending <= (pending & ~clr_m) | set_m;
            if (vw)
                visited <= '0;
            if (pc_hit)
                visited[pc_off[IW+1:2]] <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (pw[i]) begin
                    period[i] <= pnew[i];
                    cnt[i]    <= pnew[i];
                end else if (enter[i])
                    cnt[i] <= period[i];
                else if (ctrl[2*i+:2] == 2'b10 && cnt[i] != '0)
                    cnt[i] <= fire[i] ? period[i] : cnt[i] - PERIOD_W'(1);
            end
        end
    end
endmodule

// File: doc/int_injector.md
Name: int_injector

Overview:
- Multi-channel external interrupt generator for the P7 MIPS system.
- Replaces the fixed single-source "interrupt once per new PC, clear on write to 0x7f20" stimulus with a reusable, register-programmable peripheral.
- Sits on the CPU's external-device bus next to the timers and drives the CPU's external interrupt lines.
- Channel 0 keeps the legacy PC-visit behaviour. Every channel can also run periodic or software-triggered.

Parameters:
N_CH, 4, number of interrupt channels (1..8)
BASE_ADDR, 32'h0000_7f20, word-aligned base of the register window
PC_LO, 32'h0000_3000, lowest PC (inclusive) eligible for PC-visit triggering
PC_HI, 32'h0000_417f, highest PC (inclusive) eligible for PC-visit triggering
PERIOD_W, 16, width of each per-channel period register and counter

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous active-low reset: state clears on a posedge where reset==0
macroscopic_pc  input  32  architectural PC of the CPU; bits [1:0] are ignored
addr  input  32  bus address; bits [1:0] are ignored
wdata  input  32  bus write data
byteen  input  4  per-byte write enable; a write occurs iff byteen!=0 and addr hits the window
rdata  output  32  combinational read data for addr
irq  output  N_CH  interrupt lines, irq==pending register

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0x00 ACK: any write clears all pending bits (legacy ack). Read returns pending.
  - +0x04 CTRL: 2 bits per channel, channel i at [2i+1:2i]. Encodings: 00 off, 01 PC-visit (channel 0 only; treated as off on other channels), 10 periodic, 11 software-only.
  - +0x08 SET: written bits under byteen set pending[i].
  - +0x0C CLR: written bits under byteen clear pending[i].
  - +0x10 VCLR: any write clears the whole visited bitmap.
  - +0x20+4i PERIOD[i]: low PERIOD_W bits, byte-masked write.
  - Unmapped offsets read 0 and ignore writes.
- CTRL and PERIOD writes honour byteen per byte.
- Reset values: pending=0, irq=0, CTRL=32'h0000_0001 (channel 0 PC-visit, all others off), PERIOD[i]=0, counters=0, visited bitmap all 0. rdata follows the reset register contents.
- PC-visit (channel 0, mode 01):
  - Evaluate w = (macroscopic_pc & ~3).
  - Trigger when pending[0]==0, PC_LO<=w<=PC_HI, and visited[(w-PC_LO)>>2]==0.
  - On the next edge: pending[0]<=1 and visited bit <=1.
  - Bitmap depth = (PC_HI-PC_LO+1)/4 entries.
  - While pending[0]==1, PCs are not sampled and not marked.
- Periodic (mode 10):
  - Counter loads PERIOD[i] on the edge where the channel enters mode 10, and on any PERIOD[i] write.
  - Each cycle in mode 10 with counter!=0, the counter decrements.
  - When it decrements from 1 to 0, set pending[i] and reload PERIOD[i] on that same edge. This gives one event every PERIOD[i] cycles.
  - PERIOD[i]==0 never fires.
  - Leaving mode 10 freezes the counter.
- Latency:
  - Register writes take effect on the write edge; irq reflects them the following cycle.
  - A PC-visit condition on cycle t raises irq in cycle t+1.
- Simultaneous events on one edge, per bit:
  - Set sources (periodic expiry, SET write) beat clears (ACK, CLR). The event is never lost.
  - PC-visit cannot collide with a clear because it needs pending[0]==0 beforehand.
- A mode change to off does not clear an existing pending bit; software must ack it.
- Reset asserted mid-count or with irq high: everything returns to reset values on that edge, and irq=0 from the next cycle.
- rdata is purely combinational from addr and the current registers. Writes are not forwarded within the same cycle.

Test Plan:
1. Reset low 2 cycles, then high; hold pc=0x3000 → irq[0]=1 one cycle after reset release. Write ACK (addr 0x7f20, byteen 4'hf) → irq[0]=0 next cycle. pc stays 0x3000 → no re-trigger.
2. pc sequence 0x2ffc, 0x4180, 0x3002 → no irq for the first two (outside window); 0x3002 maps to 0x3000 and is already visited, so no irq. Write VCLR, then pc=0x3000 → irq[0]=1.
3. Write PERIOD[1]=5, then CTRL=32'h9 (channel 0 PC-visit, channel 1 periodic) → irq[1] rises 5 cycles after the CTRL write. Write CLR=0x2 → irq[1] clears, then re-rises 5 cycles after the previous rise.
4. Same edge: periodic expiry on channel 2 and a write of CLR=0x4 → pending[2] stays 1.
5. Write SET=0x8 with byteen 4'h1 → irq[3]=1. Write SET=0x800 with byteen 4'h1 → no change (byte 1 masked). Read offset 0x00 → rdata=32'h8.
6. Channel 1 counter mid-count (PERIOD 100, 40 cycles in), pull reset low 1 cycle → irq=0, CTRL reads 0x1, PERIOD[1] reads 0; no irq[1] for 200 cycles.
